nibble_serial_addsub_ctrl: RTL and testbench



---
 rtl/nibble_serial_addsub_pkg.sv | 17 +
 rtl/cla4_slice.sv | 28 ++
 rtl/nibble_serial_addsub_ctrl.sv | 124 ++++++++++++
 tb/tb_nibble_serial_addsub_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_addsub_pkg.sv
// rtl/nibble_serial_addsub_pkg.sv - shared types, constants and helpers for the nibble-serial add/sub controller
package nibble_serial_addsub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement overflow: operands agree in sign but the result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// rtl/cla4_slice.sv - combinational 4-bit carry-lookahead adder slice
module cla4_slice (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_i);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_i);

    assign s_o = p ^ c[3:0];
    assign c_o = c[4];

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// rtl/nibble_serial_addsub_ctrl.sv - WIDTH-bit add/sub computed one nibble per cycle through a single CLA slice
// Optional accumulate input acc_i enabled by defining ADDSUB_ACC_EN.
module nibble_serial_addsub_ctrl
    import nibble_serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             c_i,
`ifdef ADDSUB_ACC_EN
    input  logic             acc_i,
`endif
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o,
    output logic             ovf_o
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0]    a_src;
    logic [WIDTH-1:0]    s_next;
    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_c;
    logic                last;
    logic                accept;

    assign ready_o = (state == S_IDLE) && !rst_i;
    assign valid_o = (state == S_DONE);
    assign accept  = valid_i && ready_o;
    assign last    = (cnt == CNT_W'(NIBBLES - 1));

`ifdef ADDSUB_ACC_EN
    // Accumulate reuses the previous result as operand A before s_o is cleared.
    assign a_src = acc_i ? s_o : a_i;
`else
    assign a_src = a_i;
`endif

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        s_next  = s_o;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CNT_W'(i)) begin
                slice_a                         = a_q[i*NIBBLE_W +: NIBBLE_W];
                slice_b                         = b_q[i*NIBBLE_W +: NIBBLE_W];
                s_next[i*NIBBLE_W +: NIBBLE_W]  = slice_s;
            end
        end
    end

    cla4_slice u_slice (
        .a_i (slice_a),
        .b_i (slice_b),
        .c_i (carry),
        .s_o (slice_s),
        .c_o (slice_c)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s_o   <= '0;
            c_o   <= 1'b0;
            ovf_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q   <= a_src;
                        b_q   <= sub_i ? ~b_i : b_i;
                        carry <= sub_i | c_i;
                        cnt   <= '0;
                        s_o   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    s_o   <= s_next;
                    carry <= slice_c;
                    if (last) begin
                        c_o   <= slice_c;
                        ovf_o <= signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], slice_s[NIBBLE_W-1]);
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// tb/tb_nibble_serial_addsub_ctrl.sv - scoreboard bench for nibble_serial_addsub_ctrl against an arithmetic reference model
module tb_nibble_serial_addsub_ctrl;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid_i = 1'b0;
    logic             ready_i = 1'b0;
    logic             sub_i = 1'b0;
    logic             c_i = 1'b0;
    logic [WIDTH-1:0] a_i = '0;
    logic [WIDTH-1:0] b_i = '0;
    logic             ready_o;
    logic             valid_o;
    logic [WIDTH-1:0] s_o;
    logic             c_o;
    logic             ovf_o;

    nibble_serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .sub_i   (sub_i),
        .c_i     (c_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .s_o     (s_o),
        .c_o     (c_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             ovf;
        int               acc_edge;
    } exp_t;

    exp_t q[$];
    bit   mon_en   = 1'b0;
    int   rdy_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic sub, input logic cin, input int acc_edge);
        exp_t   e;
        longint u;
        int     sa;
        int     sb;
        int     r;
        sa = $signed(a);
        sb = $signed(b);
        if (sub) begin
            u   = longint'(a) - longint'(b);
            e.c = (a >= b);
            r   = sa - sb;
        end else begin
            u   = longint'(a) + longint'(b) + longint'(cin);
            e.c = (u > 65535);
            r   = sa + sb + int'(cin);
        end
        e.s        = u[WIDTH-1:0];
        e.ovf      = (r > 32767) || (r < -32768);
        e.acc_edge = acc_edge;
        return e;
    endfunction

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sub, input logic cin);
        int w;
        @(negedge clk);
        a_i = a; b_i = b; sub_i = sub; c_i = cin; valid_i = 1'b1;
        w = 0;
        while (!ready_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!ready_o) begin
            check("accept_timeout", 32'(ready_o), 32'd1);
            valid_i = 1'b0;
            return;
        end
        q.push_back(model(a, b, sub, cin, cyc + 1));
        @(posedge clk);
        #1;
        // Scramble operands after acceptance; the result must not change.
        valid_i = 1'b0;
        a_i = WIDTH'($urandom); b_i = WIDTH'($urandom);
        sub_i = 1'($urandom); c_i = 1'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("drain", 32'(q.size()), 32'd0);
    endtask

    logic [WIDTH-1:0] held_s;
    logic             held_c;
    logic             held_ovf;
    bit               prev_v = 1'b0;
    exp_t             got;

    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_v = 1'b0;
            end else begin
                ready_i = (rdy_mode == 1) ? 1'b0 :
                          (rdy_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
                if (valid_o) begin
                    check("ready_o_in_done", 32'(ready_o), 32'd0);
                    if (q.size() == 0) begin
                        check("unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        // valid_o is first seen NIBBLES edges after the accept edge.
                        if (!prev_v)
                            check("latency", 32'(cyc), 32'(q[0].acc_edge + NIBBLES));
                        else begin
                            check("hold_s", 32'(s_o), 32'(held_s));
                            check("hold_c", 32'(c_o), 32'(held_c));
                            check("hold_ovf", 32'(ovf_o), 32'(held_ovf));
                        end
                        held_s = s_o; held_c = c_o; held_ovf = ovf_o;
                        if (ready_i) begin
                            got = q.pop_front();
                            check("result_s", 32'(s_o), 32'(got.s));
                            check("result_c", 32'(c_o), 32'(got.c));
                            check("result_ovf", 32'(ovf_o), 32'(got.ovf));
                        end
                    end
                end
                prev_v = valid_o && !ready_i;
            end
        end
    end

    initial begin
        int w;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_s", 32'(s_o), 32'd0);
        check("rst_c", 32'(c_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(ready_o), 32'd1);
        mon_en = 1'b1;

        issue(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        issue(16'h0003, 16'h0005, 1'b1, 1'b0);
        issue(16'h8000, 16'h0001, 1'b1, 1'b1);
        drain();

        // Backpressure: hold ready_i low in DONE while new requests are offered.
        rdy_mode = 1;
        issue(16'h00A5, 16'h005A, 1'b0, 1'b1);
        w = 0;
        while (!valid_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("bp_reach_done", 32'(valid_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            #1;
            valid_i = 1'b1; a_i = WIDTH'($urandom); b_i = WIDTH'($urandom);
            @(negedge clk);
            #1;
            check("bp_valid_held", 32'(valid_o), 32'd1);
            check("bp_ready_low", 32'(ready_o), 32'd0);
        end
        valid_i = 1'b0;
        rdy_mode = 2;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("bp_release_ready", 32'(ready_o), 32'd1);
        check("bp_release_valid", 32'(valid_o), 32'd0);
        check("bp_queue_empty", 32'(q.size()), 32'd0);
        rdy_mode = 0;

        // Leave c_o/ovf_o set so the mid-RUN reset has something to clear.
        issue(16'h8000, 16'h0001, 1'b1, 1'b0);
        drain();
        mon_en = 1'b0;
        @(negedge clk);
        a_i = 16'hFFFF; b_i = 16'hFFFF; sub_i = 1'b0; c_i = 1'b0; valid_i = 1'b1;
        check("rr_ready", 32'(ready_o), 32'd1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rr_valid", 32'(valid_o), 32'd0);
        check("rr_s", 32'(s_o), 32'd0);
        check("rr_c", 32'(c_o), 32'd0);
        check("rr_ovf", 32'(ovf_o), 32'd0);
        check("rr_ready_in_rst", 32'(ready_o), 32'd0);
        rst = 1'b0;
        #1;
        check("rr_ready_after", 32'(ready_o), 32'd1);
        repeat (NIBBLES + 2) begin
            @(negedge clk);
            check("rr_no_pulse", 32'(valid_o), 32'd0);
        end
        mon_en = 1'b1;
        issue(16'h0001, 16'h0001, 1'b0, 1'b0);
        drain();

        for (int i = 0; i < 40; i++)
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
